md_sched: RTL

- Multi-cycle multiply/divide scheduler and HI/LO owner for the pipelined MIPS core, sitting beside the single-cycle ALU in EX.
- Accepts one mult/multu/div/divu/mthi/mtlo command from EX.
- Models the fixed operation latency with a busy counter, then commits results to HI/LO.
- Generates the stall request the hazard unit uses to hold any md-using instruction in ID.

---
 rtl/md_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler and HI/LO owner beside the EX-stage ALU.
// Results are computed on acceptance and committed when the busy window ends.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        md_use_id,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [CW-1:0] cnt;
  logic [31:0]   p_hi, p_lo;
  logic          p_wr;

  logic          is_mul, is_div, is_mc, accept;
  logic [31:0]   r_hi, r_lo;
  logic          r_wr;
  logic signed [63:0] prod_s;
  logic [63:0]   prod_u;

  assign is_mul = (md_op == OP_MULT) | (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  | (md_op == OP_DIVU);
  assign is_mc  = is_mul | is_div;
  assign accept = start & ~busy & (md_op != 3'b000) & (md_op != 3'b111);

  assign stall_req = md_use_id & (busy | (start & ~busy & is_mc));

  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

  always_comb begin
    r_hi = 32'b0;
    r_lo = 32'b0;
    r_wr = 1'b1;
    case (md_op)
      OP_MULT:  {r_hi, r_lo} = prod_s;
      OP_MULTU: {r_hi, r_lo} = prod_u;
      OP_DIV: begin
        if (op_b == 32'b0) begin
          r_wr = 1'b0;
        end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
          // quotient overflows; wrap like the hardware divider
          r_lo = 32'h8000_0000;
          r_hi = 32'b0;
        end else begin
          r_lo = $signed(op_a) / $signed(op_b);
          r_hi = $signed(op_a) % $signed(op_b);
        end
      end
      OP_DIVU: begin
        if (op_b == 32'b0) begin
          r_wr = 1'b0;
        end else begin
          r_lo = op_a / op_b;
          r_hi = op_a % op_b;
        end
      end
      default: r_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi   <= 32'b0;
      lo   <= 32'b0;
      p_hi <= 32'b0;
      p_lo <= 32'b0;
      p_wr <= 1'b0;
    end else if (busy) begin
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        p_wr <= 1'b0;
        if (p_wr) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (accept) begin
      if (md_op == OP_MTHI) begin
        hi <= op_a;
      end else if (md_op == OP_MTLO) begin
        lo <= op_a;
      end else begin
        busy <= 1'b1;
        cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        p_hi <= r_hi;
        p_lo <= r_lo;
        p_wr <= r_wr;
      end
    end
  end

endmodule
